lif_neuron: RTL and testbench
=============================

# lif_neuron

Leaky integrate-and-fire neuron core that sits directly downstream of the synapse weight table. It accepts one signed synaptic weight per handshake and accumulates it into a saturating membrane potential. When the potential reaches threshold it emits a one-cycle spike tagged with its neuron number, then holds off input for a refractory period. The spike output feeds the STDP write path back into the synapse table and the next layer's event routing.

## Interface
- WEIGHT_W, 8: signed weight width, matching the synapse table output.
- POT_W, 16: signed membrane potential width.
- THRESHOLD, 1000: firing threshold; must satisfy 0 < THRESHOLD ≤ 2^(POT_W-1)-1.
- LEAK_SHIFT, 4: leak amount is potential >>> LEAK_SHIFT.
- LEAK_PERIOD, 16: cycles between leak ticks; must be ≥ 1.
- REFRAC_CYCLES, 8: refractory length in cycles; must be ≥ 1.
- NEURON_ID, 0: 8-bit neuron number reported with each spike.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- kill  in  1  synchronous clear of all state; highest priority after rst.
- w_valid  in  1  weight present.
- w_ready  out  1  core can accept a weight.
- w_data  in  WEIGHT_W  signed synaptic weight.
- spike_out  out  1  one-cycle fire pulse.
- spike_id  out  8  NEURON_ID, valid while spike_out=1, otherwise 0.
- potential  out  POT_W  current membrane potential (registered).
- dropped_cnt  out  8  number of weights discarded during refractory; saturates at 255.

## Operation
- FSM states: INTEG, FIRE, REFRAC.
- INTEG:
  - w_ready=1. An accept occurs when w_valid && w_ready at a rising edge.
  - On accept, potential <= sat(potential' + sext(w_data)).
  - potential' is the potential after any leak due in the same cycle; otherwise it is the current potential.
  - If the new potential is ≥ THRESHOLD, go to FIRE.
- FIRE (exactly 1 cycle):
  - spike_out=1, spike_id=NEURON_ID, w_ready=0.
  - potential <= 0.
  - Then go to REFRAC with the refractory counter loaded to REFRAC_CYCLES-1.
- REFRAC:
  - w_ready=1. Accepted weights are discarded and dropped_cnt increments (saturating).
  - Potential is held at 0. No leak is applied.
  - When the counter is 0, go to INTEG.
- Saturation: sums clamp to [-2^(POT_W-1), 2^(POT_W-1)-1]. There is no wrap-around.
- Leak tick:
  - Only in INTEG. A free counter 0..LEAK_PERIOD-1 ticks when it reaches LEAK_PERIOD-1.
  - On a tick, potential <= potential - (potential >>> LEAK_SHIFT). This is an arithmetic shift, so negative values move toward 0.
  - The leak counter resets to 0 on entering INTEG.
- kill:
  - state <= INTEG, potential <= 0, all counters <= 0 (including dropped_cnt), spike_out <= 0.
  - A w_data offered in the same cycle is not accepted (w_ready=0 while kill=1).

## Timing
- Reset values: state INTEG, potential 0, spike_out 0, spike_id 0, dropped_cnt 0, w_ready 1 (combinational from state and kill).
- Latency: a weight accepted at edge N is visible on potential after edge N. If it crosses threshold, spike_out is high during cycle N+1.
- Refractory: REFRAC lasts exactly REFRAC_CYCLES cycles. The first post-spike weight can be integrated at earliest REFRAC_CYCLES+1 cycles after spike_out rises.
- Throughput: one weight per cycle in INTEG.
- rst asserted mid-FIRE or mid-REFRAC: immediate return to reset values. No spike is emitted after release.

## Configuration
- LIF_LEAK_EN:
  - Defined: leak counter and leak tick are present as described.
  - Undefined: no leak logic is compiled. The neuron is pure integrate-and-fire, and LEAK_SHIFT and LEAK_PERIOD are ignored.

## Structure
- Shared package lif_pkg holds:
  - the state enum lif_state_t {INTEG, FIRE, REFRAC};
  - the saturating signed add function;
  - the default weight and potential width constants, shared with the synapse table.
- One sub-module, lif_leak_unit:
  - owns the leak period counter and the shift-subtract;
  - outputs the leaked potential plus a tick flag;
  - is instantiated only under LIF_LEAK_EN.

## Test plan
- THRESHOLD=100, leak off: weights 60 then 50 on consecutive cycles -> potential 60, then 110; spike_out=1 next cycle with spike_id=NEURON_ID; potential 0 after.
- REFRAC_CYCLES=8: weight 127 offered every cycle after a spike -> the 8 refractory weights are dropped (dropped_cnt=8, potential stays 0); the 9th is integrated (potential 127).
- POT_W=16, THRESHOLD=32767: repeated +127 -> potential clamps at 32767 and fires. Repeated -128 from 0 -> clamps at -32768, with no wrap.
- LIF_LEAK_EN, LEAK_SHIFT=4, LEAK_PERIOD=16: potential 160 with no input -> 150 at the first tick. Potential -160 -> -150.
- Leak tick and weight +10 in the same cycle with potential 160 -> 160 (150+10).
- kill asserted during REFRAC with dropped_cnt=3 -> next cycle state INTEG, potential 0, dropped_cnt 0, no spike; rst low during FIRE -> spike_out 0 immediately.

Source files
------------

// File: rtl/lif_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : lif_pkg                                                |
// | Description : Shared types, widths and saturating add for the LIF    |
// |               neuron core and the synapse table feeding it.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package lif_pkg;

   // Default widths, shared with the synapse weight table.
   localparam int LIF_WEIGHT_W = 8;
   localparam int LIF_POT_W    = 16;

   typedef enum logic [1:0] {
      INTEG  = 2'd0,
      FIRE   = 2'd1,
      REFRAC = 2'd2
   } lif_state_t;

   // Signed add clamped to the range of an i_width-bit two's complement value.
   // Operands must already lie inside a 32-bit range; i_width must be <= 32.
   function automatic logic signed [31:0] sat_add(
      input logic signed [31:0] i_a,
      input logic signed [31:0] i_b,
      input int                 i_width
   );
      logic signed [32:0] w_sum;
      logic signed [32:0] w_hi;
      logic signed [32:0] w_lo;
      w_sum = 33'(i_a) + 33'(i_b);
      w_hi  = (33'sd1 <<< (i_width - 1)) - 33'sd1;
      w_lo  = -w_hi - 33'sd1;
      if (w_sum > w_hi) begin
         w_sum = w_hi;
      end else if (w_sum < w_lo) begin
         w_sum = w_lo;
      end
      return w_sum[31:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/lif_neuron_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : lif_neuron_if                                          |
// | Description : Weight handshake, kill and spike/status bundle of the  |
// |               LIF neuron core. master = upstream driver, slave =     |
// |               neuron core.                                           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface lif_neuron_if
   import lif_pkg::*;
#(
   parameter int WEIGHT_W = LIF_WEIGHT_W,
   parameter int POT_W    = LIF_POT_W
) ();

   logic                       kill;
   logic                       w_valid;
   logic                       w_ready;
   logic signed [WEIGHT_W-1:0] w_data;
   logic                       spike_out;
   logic [7:0]                 spike_id;
   logic signed [POT_W-1:0]    potential;
   logic [7:0]                 dropped_cnt;

   modport master (
      output kill, w_valid, w_data,
      input  w_ready, spike_out, spike_id, potential, dropped_cnt
   );

   modport slave (
      input  kill, w_valid, w_data,
      output w_ready, spike_out, spike_id, potential, dropped_cnt
   );

endinterface
`default_nettype wire

// File: rtl/lif_leak_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : lif_leak_unit                                          |
// | Description : Leak period counter plus shift-subtract. o_leaked is   |
// |               i_pot - (i_pot >>> LEAK_SHIFT); o_tick marks the cycle |
// |               in which the leaked value should be used. i_clear      |
// |               holds the counter at 0 (outside integration / kill).   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module lif_leak_unit #(
   parameter int POT_W       = 16,
   parameter int LEAK_SHIFT  = 4,
   parameter int LEAK_PERIOD = 16
) (
   input  wire logic                    clk,
   input  wire logic                    rst,
   input  wire logic                    i_clear,
   input  wire logic signed [POT_W-1:0] i_pot,
   output logic signed [POT_W-1:0]      o_leaked,
   output logic                         o_tick
);

   localparam int                 c_CNT_W = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(LEAK_PERIOD - 1);

   logic [c_CNT_W-1:0] r_cnt;

   // Free-running 0..LEAK_PERIOD-1 counter, parked at 0 while cleared.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (i_clear || (r_cnt == c_LAST)) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_tick   = !i_clear && (r_cnt == c_LAST);
   // Arithmetic shift: negative potentials decay toward zero, never past it.
   assign o_leaked = i_pot - (i_pot >>> LEAK_SHIFT);

endmodule
`default_nettype wire

// File: rtl/lif_neuron.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : lif_neuron                                             |
// | Description : Leaky integrate-and-fire neuron core. Integrates one   |
// |               signed weight per handshake into a saturating membrane |
// |               potential, fires a one-cycle tagged spike at threshold |
// |               and then drops input for a refractory period.          |
// |               Build option LIF_LEAK_EN: compiles in the periodic     |
// |               leak (lif_leak_unit); otherwise pure integrate-fire.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module lif_neuron
   import lif_pkg::*;
#(
   parameter int         WEIGHT_W      = LIF_WEIGHT_W,
   parameter int         POT_W         = LIF_POT_W,
   parameter int         THRESHOLD     = 1000,
   parameter int         LEAK_SHIFT    = 4,
   parameter int         LEAK_PERIOD   = 16,
   parameter int         REFRAC_CYCLES = 8,
   parameter logic [7:0] NEURON_ID     = 8'd0
) (
   input wire logic    clk,
   input wire logic    rst,
   lif_neuron_if.slave lif_bus
);

   localparam int                      c_RC_W    = $clog2(REFRAC_CYCLES + 1);
   localparam logic [c_RC_W-1:0]       c_RC_LOAD = c_RC_W'(REFRAC_CYCLES - 1);
   localparam logic signed [POT_W-1:0] c_THRESH  = POT_W'(THRESHOLD);

   // Elaboration-time parameter range checks.
   if ((THRESHOLD < 1) || (THRESHOLD > (2 ** (POT_W - 1)) - 1)) begin : g_bad_threshold
      $error("lif_neuron: THRESHOLD out of range");
   end
   if (REFRAC_CYCLES < 1) begin : g_bad_refrac
      $error("lif_neuron: REFRAC_CYCLES must be >= 1");
   end
   if ((LEAK_PERIOD < 1) || (LEAK_SHIFT < 0) || (LEAK_SHIFT >= POT_W)) begin : g_bad_leak
      $error("lif_neuron: leak parameters out of range");
   end

   lif_state_t              r_state;
   lif_state_t              w_state_nxt;
   logic signed [POT_W-1:0] r_pot;
   logic signed [POT_W-1:0] w_pot_nxt;
   logic signed [POT_W-1:0] w_pot_base;
   logic signed [POT_W-1:0] w_leaked;
   logic signed [POT_W-1:0] w_sum;
   logic [c_RC_W-1:0]       r_refrac;
   logic [c_RC_W-1:0]       w_refrac_nxt;
   logic [7:0]              r_dropped;
   logic [7:0]              w_dropped_nxt;
   logic                    w_tick;
   logic                    w_accept;

`ifdef LIF_LEAK_EN
   logic w_leak_clear;

   // Leak period restarts whenever integration is (re)entered.
   assign w_leak_clear = lif_bus.kill || (r_state != INTEG);

   lif_leak_unit #(
      .POT_W       (POT_W),
      .LEAK_SHIFT  (LEAK_SHIFT),
      .LEAK_PERIOD (LEAK_PERIOD)
   ) u_leak (
      .clk      (clk),
      .rst      (rst),
      .i_clear  (w_leak_clear),
      .i_pot    (r_pot),
      .o_leaked (w_leaked),
      .o_tick   (w_tick)
   );
`else
   assign w_leaked = r_pot;
   assign w_tick   = 1'b0;
`endif

   assign lif_bus.w_ready = !lif_bus.kill && (r_state != FIRE);
   assign w_accept        = lif_bus.w_valid && lif_bus.w_ready;
   // A leak due this cycle is applied before the incoming weight is added.
   assign w_pot_base      = w_tick ? w_leaked : r_pot;
   assign w_sum           = POT_W'(sat_add(32'(w_pot_base), 32'(lif_bus.w_data), POT_W));

   // State, potential and counters; asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= INTEG;
         r_pot     <= '0;
         r_refrac  <= '0;
         r_dropped <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_pot     <= w_pot_nxt;
         r_refrac  <= w_refrac_nxt;
         r_dropped <= w_dropped_nxt;
      end
   end

   // Next-state, next-potential and spike outputs; kill overrides everything.
   always_comb begin
      w_state_nxt         = r_state;
      w_pot_nxt           = r_pot;
      w_refrac_nxt        = r_refrac;
      w_dropped_nxt       = r_dropped;
      lif_bus.spike_out   = (r_state == FIRE);
      lif_bus.spike_id    = (r_state == FIRE) ? NEURON_ID : 8'd0;
      lif_bus.potential   = r_pot;
      lif_bus.dropped_cnt = r_dropped;

      if (lif_bus.kill) begin
         w_state_nxt   = INTEG;
         w_pot_nxt     = '0;
         w_refrac_nxt  = '0;
         w_dropped_nxt = '0;
      end else begin
         case (r_state)
            INTEG: begin
               w_pot_nxt = w_accept ? w_sum : w_pot_base;
               if (w_accept && (w_sum >= c_THRESH)) begin
                  w_state_nxt = FIRE;
               end
            end
            FIRE: begin
               w_pot_nxt    = '0;
               w_refrac_nxt = c_RC_LOAD;
               w_state_nxt  = REFRAC;
            end
            REFRAC: begin
               w_pot_nxt = '0;
               if (w_accept && (r_dropped != 8'hFF)) begin
                  w_dropped_nxt = r_dropped + 8'd1;
               end
               if (r_refrac == '0) begin
                  w_state_nxt = INTEG;
               end else begin
                  w_refrac_nxt = r_refrac - 1'b1;
               end
            end
            default: begin
               w_state_nxt = INTEG;
               w_pot_nxt   = '0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lif_neuron.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_lif_neuron                                          |
// | Description : Self-checking bench for lif_neuron. Two instances      |
// |               (low and maximal threshold) are compared every cycle   |
// |               against a behavioural model, plus directed checks.     |
// |               Honours LIF_LEAK_EN the same way as the design.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_lif_neuron;

   localparam int         REFRAC = 8;
   localparam int         LSHIFT = 4;
   localparam int         LPER   = 16;
   localparam int         TH_A   = 100;
   localparam int         TH_B   = 32767;
   localparam logic [7:0] ID_A   = 8'h2A;
   localparam logic [7:0] ID_B   = 8'h07;

   localparam int P_INTEG  = 0;
   localparam int P_FIRE   = 1;
   localparam int P_REFRAC = 2;

   typedef struct {
      int pot;
      int phase;
      int rleft;
      int dropped;
      int lcyc;
      int thresh;
   } model_t;

   logic   clk;
   logic   rst;
   int     n_pass;
   int     n_total;
   model_t ma;
   model_t mb;

   lif_neuron_if #(.WEIGHT_W(8), .POT_W(16)) ifa ();
   lif_neuron_if #(.WEIGHT_W(8), .POT_W(16)) ifb ();

   lif_neuron #(
      .WEIGHT_W(8), .POT_W(16), .THRESHOLD(TH_A), .LEAK_SHIFT(LSHIFT),
      .LEAK_PERIOD(LPER), .REFRAC_CYCLES(REFRAC), .NEURON_ID(ID_A)
   ) dut_a (
      .clk(clk), .rst(rst), .lif_bus(ifa)
   );

   lif_neuron #(
      .WEIGHT_W(8), .POT_W(16), .THRESHOLD(TH_B), .LEAK_SHIFT(LSHIFT),
      .LEAK_PERIOD(LPER), .REFRAC_CYCLES(REFRAC), .NEURON_ID(ID_B)
   ) dut_b (
      .clk(clk), .rst(rst), .lif_bus(ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic model_t m_init(input int thresh);
      model_t m;
      m.pot = 0; m.phase = P_INTEG; m.rleft = 0; m.dropped = 0; m.lcyc = 0;
      m.thresh = thresh;
      return m;
   endfunction

   function automatic int clamp16(input int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   // One clock edge of the neuron as described behaviourally.
   function automatic model_t m_step(input model_t m, input bit kill, input bit valid, input int data);
      model_t n;
      int     p;
      n = m;
      if (kill) begin
         n = m_init(m.thresh);
         return n;
      end
      case (m.phase)
         P_INTEG: begin
            p = m.pot;
`ifdef LIF_LEAK_EN
            if (m.lcyc == LPER - 1) begin
               p = p - (p >>> LSHIFT);
               n.lcyc = 0;
            end else begin
               n.lcyc = m.lcyc + 1;
            end
`endif
            if (valid) begin
               p = clamp16(p + data);
               if (p >= m.thresh) n.phase = P_FIRE;
            end
            n.pot = p;
         end
         P_FIRE: begin
            n.pot = 0; n.phase = P_REFRAC; n.rleft = REFRAC; n.lcyc = 0;
         end
         default: begin
            if (valid) n.dropped = (m.dropped < 255) ? m.dropped + 1 : 255;
            n.rleft = m.rleft - 1;
            if (n.rleft == 0) begin
               n.phase = P_INTEG;
               n.lcyc  = 0;
            end
         end
      endcase
      return n;
   endfunction

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic check_all();
      chk("a_ready", ifa.w_ready, (!ifa.kill && ma.phase != P_FIRE));
      chk("a_spike", ifa.spike_out, (ma.phase == P_FIRE));
      chk("a_id", ifa.spike_id, (ma.phase == P_FIRE) ? ID_A : 8'd0);
      chk("a_pot", ifa.potential, ma.pot);
      chk("a_drop", ifa.dropped_cnt, ma.dropped);
      chk("b_ready", ifb.w_ready, (!ifb.kill && mb.phase != P_FIRE));
      chk("b_spike", ifb.spike_out, (mb.phase == P_FIRE));
      chk("b_id", ifb.spike_id, (mb.phase == P_FIRE) ? ID_B : 8'd0);
      chk("b_pot", ifb.potential, mb.pot);
      chk("b_drop", ifb.dropped_cnt, mb.dropped);
   endtask

   task automatic set_a(input bit k, input bit v, input int d);
      ifa.kill = k; ifa.w_valid = v; ifa.w_data = 8'(d);
   endtask

   task automatic set_b(input bit k, input bit v, input int d);
      ifb.kill = k; ifb.w_valid = v; ifb.w_data = 8'(d);
   endtask

   // Check settled outputs, then let one edge pass and advance the models.
   task automatic cycle();
      #1;
      check_all();
      @(posedge clk);
      ma = m_step(ma, ifa.kill, ifa.w_valid, int'(ifa.w_data));
      mb = m_step(mb, ifb.kill, ifb.w_valid, int'(ifb.w_data));
      #1;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      rst     = 1'b0;
      set_a(0, 0, 0);
      set_b(0, 0, 0);
      ma = m_init(TH_A);
      mb = m_init(TH_B);

      // Reset state
      #1;
      check_all();
      chk("rst_ready", ifa.w_ready, 1);
      #20;
      rst = 1'b1;
      cycle();

      // Threshold crossing: 60 then 50
      set_a(0, 1, 60);  cycle(); chk("a_pot60", ifa.potential, 60);
      set_a(0, 1, 50);  cycle(); chk("a_pot110", ifa.potential, 110);
      chk("a_fire", ifa.spike_out, 1);
      chk("a_fire_id", ifa.spike_id, ID_A);

      // Weight 127 every cycle after the spike: 8 dropped, 9th integrated
      set_a(0, 1, 127); cycle(); chk("a_pot_after_fire", ifa.potential, 0);
      repeat (REFRAC) cycle();
      chk("a_drop8", ifa.dropped_cnt, 8);
      chk("a_pot_refrac", ifa.potential, 0);
      cycle(); chk("a_first_post", ifa.potential, 127);
      set_a(0, 0, 0);
      cycle();
      repeat (REFRAC) cycle();

      // kill during refractory with three drops
      set_a(1, 0, 0);   cycle();
      set_a(0, 1, 127); cycle();
      set_a(0, 1, 1);   cycle();
      repeat (3) cycle();
      chk("a_drop3", ifa.dropped_cnt, 3);
      set_a(1, 1, 1);
      #1 chk("a_kill_ready", ifa.w_ready, 0);
      cycle();
      chk("a_kill_pot", ifa.potential, 0);
      chk("a_kill_drop", ifa.dropped_cnt, 0);
      chk("a_kill_spike", ifa.spike_out, 0);
      set_a(0, 1, 5);   cycle(); chk("a_after_kill", ifa.potential, 5);

      // Asynchronous reset in the middle of FIRE
      set_a(1, 0, 0);   cycle();
      set_a(0, 1, 60);  cycle();
      set_a(0, 1, 50);  cycle(); chk("a_fire2", ifa.spike_out, 1);
      set_a(0, 0, 0);
      rst = 1'b0;
      #1;
      chk("a_rst_spike", ifa.spike_out, 0);
      chk("a_rst_pot", ifa.potential, 0);
      ma = m_init(TH_A);
      mb = m_init(TH_B);
      #12;
      rst = 1'b1;
      repeat (4) cycle();

`ifndef LIF_LEAK_EN
      // Positive saturation fires at 32767; negative clamps at -32768
      set_b(1, 0, 0);    cycle();
      set_b(0, 1, 127);  repeat (258) cycle();
      chk("b_pot_32766", ifb.potential, 32766);
      cycle();
      chk("b_sat_hi", ifb.potential, 32767);
      chk("b_sat_fire", ifb.spike_out, 1);
      set_b(0, 0, 0);    cycle();
      repeat (REFRAC) cycle();
      set_b(1, 0, 0);    cycle();
      set_b(0, 1, -128); repeat (256) cycle();
      chk("b_pot_min", ifb.potential, -32768);
      cycle();
      chk("b_sat_lo", ifb.potential, -32768);
      chk("b_sat_lo_spike", ifb.spike_out, 0);
      set_b(0, 0, 0);    cycle();
`else
      // Leak: 160 -> 150, tick coinciding with +10 keeps 160, -160 -> -150
      set_b(1, 0, 0);    cycle();
      set_b(0, 1, 127);  cycle();
      set_b(0, 1, 33);   cycle();
      set_b(0, 0, 0);    repeat (13) cycle();
      chk("b_pre_tick", ifb.potential, 160);
      set_b(0, 1, 10);   cycle();
      chk("b_tick_plus_w", ifb.potential, 160);
      set_b(0, 0, 0);    repeat (15) cycle();
      chk("b_pre_tick2", ifb.potential, 160);
      cycle();
      chk("b_leak_pos", ifb.potential, 150);
      set_b(1, 0, 0);    cycle();
      set_b(0, 1, -128); cycle();
      set_b(0, 1, -32);  cycle();
      set_b(0, 0, 0);    repeat (14) cycle();
      chk("b_leak_neg", ifb.potential, -150);
`endif

      // Randomized traffic on both instances
      for (int i = 0; i < 800; i++) begin
         set_a($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7,
               int'($urandom_range(0, 255)) - 128);
         set_b($urandom_range(0, 399) == 0, $urandom_range(0, 9) < 7,
               int'($urandom_range(0, 255)) - 100);
         cycle();
      end
      set_a(0, 0, 0);
      set_b(0, 0, 0);
      cycle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
